// File: rtl/pfxsum_pkg.sv
// Shared constants and helpers for the streaming prefix-sum engine.
package pfxsum_pkg;

  localparam logic MODE_INCL = 1'b0;
  localparam logic MODE_EXCL = 1'b1;

  // Ceiling log2 for tools without $clog2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pfxsum_level.sv
// One registered Kogge-Stone level: lane i picks up lane i-DIST, valid and sideband ride along.
module pfxsum_level #(
  parameter int OWIDTH = 11,
  parameter int V_LEN  = 8,
  parameter int DIST   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    vld,
  input  logic                    excl,
  input  logic                    last,
  input  logic [OWIDTH*V_LEN-1:0] lanes,
  output logic                    q_vld,
  output logic                    q_excl,
  output logic                    q_last,
  output logic [OWIDTH*V_LEN-1:0] q_lanes
);

  logic [OWIDTH*V_LEN-1:0] sum;

  for (genvar i = 0; i < V_LEN; i++) begin : g_lane
    if (i >= DIST) begin : g_add
      assign sum[i*OWIDTH +: OWIDTH] = lanes[i*OWIDTH +: OWIDTH] + lanes[(i-DIST)*OWIDTH +: OWIDTH];
    end else begin : g_pass
      assign sum[i*OWIDTH +: OWIDTH] = lanes[i*OWIDTH +: OWIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_vld <= 1'b0;
    else if (en) q_vld <= vld;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      q_excl  <= excl;
      q_last  <= last;
      q_lanes <= sum;
    end
  end

endmodule

// File: rtl/pfxsum_stream.sv
// Streaming segmented prefix sum: input stage, Kogge-Stone levels, output/carry stage,
// all advanced by one global enable derived from the output handshake.
module pfxsum_stream
  import pfxsum_pkg::*;
#(
  parameter int IWIDTH = 8,
  parameter int V_LEN  = 8,
  parameter int OWIDTH = IWIDTH + $clog2(V_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [IWIDTH*V_LEN-1:0] ivec,
  input  logic                    excl_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [OWIDTH*V_LEN-1:0] ovec,
  output logic [OWIDTH-1:0]       total_out,
  output logic                    last_out
);

  localparam int STAGES = clog2(V_LEN);
  localparam int VW     = OWIDTH * V_LEN;

  logic              en;
  logic              vld_p0;
  logic              excl_p0;
  logic              last_p0;
  logic [VW-1:0]     lanes_p0;
  logic              vld_lv   [STAGES];
  logic              excl_lv  [STAGES];
  logic              last_lv  [STAGES];
  logic [VW-1:0]     lanes_lv [STAGES];
  logic [OWIDTH-1:0] carry;
  logic [VW-1:0]     s_last;
  logic [VW-1:0]     s_sh;
  logic [VW-1:0]     ovec_nxt;
  logic [OWIDTH-1:0] total_nxt;

  // Whole pipeline moves together; nothing advances while the output is stalled.
  assign en       = !valid_out || ready_out;
  assign ready_in = en;

  // Stage p0: register the beat and zero-extend lanes to the output width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else if (en) vld_p0 <= valid_in;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      excl_p0 <= excl_in;
      last_p0 <= last_in;
      for (int i = 0; i < V_LEN; i++)
        lanes_p0[i*OWIDTH +: OWIDTH] <= OWIDTH'(ivec[i*IWIDTH +: IWIDTH]);
    end
  end

  // Kogge-Stone levels, distance doubling per level
  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    logic          v_i;
    logic          e_i;
    logic          l_i;
    logic [VW-1:0] d_i;

    if (k == 0) begin : g_first
      assign v_i = vld_p0;
      assign e_i = excl_p0;
      assign l_i = last_p0;
      assign d_i = lanes_p0;
    end else begin : g_next
      assign v_i = vld_lv[k-1];
      assign e_i = excl_lv[k-1];
      assign l_i = last_lv[k-1];
      assign d_i = lanes_lv[k-1];
    end

    pfxsum_level #(
      .OWIDTH (OWIDTH),
      .V_LEN  (V_LEN),
      .DIST   (1 << k)
    ) u_lvl (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .vld     (v_i),
      .excl    (e_i),
      .last    (l_i),
      .lanes   (d_i),
      .q_vld   (vld_lv[k]),
      .q_excl  (excl_lv[k]),
      .q_last  (last_lv[k]),
      .q_lanes (lanes_lv[k])
    );
  end

  // Output stage: add the segment carry; exclusive mode uses the sums shifted up one lane
  assign s_last    = lanes_lv[STAGES-1];
  assign s_sh      = {s_last[VW-OWIDTH-1:0], {OWIDTH{1'b0}}};
  assign total_nxt = carry + s_last[VW-1 -: OWIDTH];

  always_comb begin
    ovec_nxt = '0;
    for (int i = 0; i < V_LEN; i++) begin
      if (excl_lv[STAGES-1] == MODE_EXCL)
        ovec_nxt[i*OWIDTH +: OWIDTH] = carry + s_sh[i*OWIDTH +: OWIDTH];
      else
        ovec_nxt[i*OWIDTH +: OWIDTH] = carry + s_last[i*OWIDTH +: OWIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      ovec      <= '0;
      total_out <= '0;
      last_out  <= 1'b0;
      carry     <= '0;
    end else if (en) begin
      valid_out <= vld_lv[STAGES-1];
      if (vld_lv[STAGES-1]) begin
        ovec      <= ovec_nxt;
        total_out <= total_nxt;
        last_out  <= last_lv[STAGES-1];
        carry     <= last_lv[STAGES-1] ? '0 : total_nxt;
      end
    end
  end

endmodule
